// File: rtl/conf_pkg.sv
// Shared definitions for the configuration BRAM loader and decoder.
// The word layout and the ret-flag position must agree on both sides.
package conf_pkg;

  localparam int CONF_DATA_WIDTH = 15;
  localparam int CONF_ADDR_WIDTH = 9;
  localparam int RAMB36_WIDTH    = 72;
  localparam int RET_BIT         = CONF_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  function automatic logic [RAMB36_WIDTH-1:0] pack_word(
    input logic [CONF_DATA_WIDTH-1:0] data,
    input logic                       ret
  );
    logic [RAMB36_WIDTH-1:0] word;
    word                      = {RAMB36_WIDTH{1'b0}};
    word[CONF_DATA_WIDTH-1:0] = data;
    word[RET_BIT]             = ret;
    return word;
  endfunction

  function automatic logic ret_flag(input logic [RAMB36_WIDTH-1:0] word);
    return word[RET_BIT];
  endfunction

endpackage

// File: rtl/conf_encoder_if.sv
// Valid/ready stream carrying configuration entries into the loader.
interface conf_encoder_if
  import conf_pkg::*;
  ;

  logic                       cfg_in_vld;
  logic [CONF_DATA_WIDTH-1:0] cfg_in_data;
  logic                       cfg_in_last;
  logic                       cfg_in_rdy;

  modport master (
    output cfg_in_vld,
    output cfg_in_data,
    output cfg_in_last,
    input  cfg_in_rdy
  );

  modport slave (
    input  cfg_in_vld,
    input  cfg_in_data,
    input  cfg_in_last,
    output cfg_in_rdy
  );

endinterface

// File: rtl/conf_encoder_chk.sv
// Protocol checks for the configuration loader outputs.
module conf_encoder_chk (
  input logic clk,
  input logic rst,
  input logic cfg_in_vld,
  input logic cfg_in_rdy,
  input logic conf_bram_wr_en,
  input logic conf_valid,
  input logic load_err
);

  logic accept_r;

  // Remembers whether a beat was accepted in the previous cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_r <= 1'b0;
    end else begin
      accept_r <= cfg_in_vld & cfg_in_rdy;
    end
  end

  a_write_follows_accept : assert property (
    @(posedge clk) disable iff (rst) conf_bram_wr_en == accept_r
  );

  a_valid_err_exclusive : assert property (
    @(posedge clk) disable iff (rst) !(conf_valid && load_err)
  );

endmodule

// File: rtl/conf_encoder_word_pack.sv
// Packs one configuration entry plus its ret flag into a BRAM word.
module conf_encoder_word_pack
  import conf_pkg::*;
(
  input  logic [CONF_DATA_WIDTH-1:0] data,
  input  logic                       ret,
  output logic [RAMB36_WIDTH-1:0]    word
);

  assign word = pack_word(data, ret);

endmodule

// File: rtl/conf_encoder.sv
// Loads a configuration table into the SWIN_BRAM, one word per accepted entry,
// flagging the final word with ret and reporting completion or overflow.
module conf_encoder
  import conf_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  conf_encoder_if.slave              cfg,
  output logic                       conf_bram_wr_en,
  output logic [CONF_ADDR_WIDTH-1:0] conf_bram_wr_addr,
  output logic [RAMB36_WIDTH-1:0]    conf_bram_wr_data,
  output logic                       conf_valid,
  output logic                       load_err,
  output logic [CONF_ADDR_WIDTH:0]   entry_cnt
);

  localparam logic [CONF_ADDR_WIDTH-1:0] PTR_MAX  = {CONF_ADDR_WIDTH{1'b1}};
  localparam logic [CONF_ADDR_WIDTH-1:0] PTR_ONE  = CONF_ADDR_WIDTH'(1);
  localparam logic [CONF_ADDR_WIDTH:0]   CNT_ONE  = (CONF_ADDR_WIDTH + 1)'(1);

  state_t                       state_r;
  state_t                       next_state_s;
  logic                         rdy_r;
  logic [CONF_ADDR_WIDTH-1:0]   ptr_r;
  logic [CONF_ADDR_WIDTH:0]     cnt_r;
  logic                         wr_en_r;
  logic [CONF_ADDR_WIDTH-1:0]   wr_addr_r;
  logic [RAMB36_WIDTH-1:0]      wr_data_r;
  logic                         valid_r;
  logic                         err_r;

  logic                         accept_s;
  logic                         at_end_s;
  logic                         ret_s;
  logic                         restart_s;
  logic [RAMB36_WIDTH-1:0]      word_s;

  assign accept_s  = cfg.cfg_in_vld & rdy_r;
  assign at_end_s  = (ptr_r == PTR_MAX);
  // Overflowing beat still carries ret so the decoder wraps inside the table
  assign ret_s     = cfg.cfg_in_last | at_end_s;
  assign restart_s = start & (state_r != ST_LOAD);

  conf_encoder_word_pack u_pack (
    .data (cfg.cfg_in_data),
    .ret  (ret_s),
    .word (word_s)
  );

  // Load state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state selection
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          next_state_s = ST_LOAD;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (accept_s && cfg.cfg_in_last) begin
          next_state_s = ST_DONE;
        end else if (accept_s && at_end_s) begin
          next_state_s = ST_ERR;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Write pointer, BRAM write port and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_r     <= 1'b0;
      ptr_r     <= {CONF_ADDR_WIDTH{1'b0}};
      cnt_r     <= {(CONF_ADDR_WIDTH + 1){1'b0}};
      wr_en_r   <= 1'b0;
      wr_addr_r <= {CONF_ADDR_WIDTH{1'b0}};
      wr_data_r <= {RAMB36_WIDTH{1'b0}};
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      rdy_r <= (next_state_s == ST_LOAD);
      if (restart_s) begin
        ptr_r   <= {CONF_ADDR_WIDTH{1'b0}};
        cnt_r   <= {(CONF_ADDR_WIDTH + 1){1'b0}};
        wr_en_r <= 1'b0;
        valid_r <= 1'b0;
        err_r   <= 1'b0;
      end else if (accept_s) begin
        wr_en_r   <= 1'b1;
        wr_addr_r <= ptr_r;
        wr_data_r <= word_s;
        ptr_r     <= ptr_r + PTR_ONE;
        cnt_r     <= cnt_r + CNT_ONE;
        if (cfg.cfg_in_last) begin
          valid_r <= 1'b1;
        end else if (at_end_s) begin
          err_r <= 1'b1;
        end else begin
          valid_r <= valid_r;
        end
      end else begin
        wr_en_r <= 1'b0;
      end
    end
  end

  assign cfg.cfg_in_rdy      = rdy_r;
  assign conf_bram_wr_en     = wr_en_r;
  assign conf_bram_wr_addr   = wr_addr_r;
  assign conf_bram_wr_data   = wr_data_r;
  assign conf_valid          = valid_r;
  assign load_err            = err_r;
  assign entry_cnt           = cnt_r;

endmodule

// File: tb/tb_conf_encoder.sv
// Randomized and directed checks of conf_encoder against a table-level model.
module tb_conf_encoder;
  import conf_pkg::*;

  logic clk;
  logic rst;
  logic start;
  logic                       conf_bram_wr_en;
  logic [CONF_ADDR_WIDTH-1:0] conf_bram_wr_addr;
  logic [RAMB36_WIDTH-1:0]    conf_bram_wr_data;
  logic                       conf_valid;
  logic                       load_err;
  logic [CONF_ADDR_WIDTH:0]   entry_cnt;

  conf_encoder_if cfg_if ();

  conf_encoder dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .cfg               (cfg_if),
    .conf_bram_wr_en   (conf_bram_wr_en),
    .conf_bram_wr_addr (conf_bram_wr_addr),
    .conf_bram_wr_data (conf_bram_wr_data),
    .conf_valid        (conf_valid),
    .load_err          (load_err),
    .entry_cnt         (entry_cnt)
  );

  conf_encoder_chk u_chk (
    .clk             (clk),
    .rst             (rst),
    .cfg_in_vld      (cfg_if.cfg_in_vld),
    .cfg_in_rdy      (cfg_if.cfg_in_rdy),
    .conf_bram_wr_en (conf_bram_wr_en),
    .conf_valid      (conf_valid),
    .load_err        (load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model of the table load: are we loading, how many entries so far, last write.
  bit          m_load;
  logic        e_rdy;
  logic        e_wr_en;
  logic [8:0]  e_addr;
  logic [71:0] e_data;
  logic        e_valid;
  logic        e_err;
  logic [9:0]  e_cnt;

  logic [71:0] mem [512];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_load = 1'b0; e_rdy = 1'b0; e_wr_en = 1'b0; e_addr = 9'd0;
    e_data = 72'd0; e_valid = 1'b0; e_err = 1'b0; e_cnt = 10'd0;
  endtask

  task automatic model_step(input logic s, input logic v, input logic l, input logic [14:0] d);
    logic ret;
    e_wr_en = 1'b0;
    if (!m_load) begin
      if (s) begin
        m_load = 1'b1; e_cnt = 10'd0; e_valid = 1'b0; e_err = 1'b0;
      end
    end else if (v) begin
      ret = l || (e_cnt == 10'd511);
      e_wr_en = 1'b1;
      e_addr  = e_cnt[8:0];
      e_data  = {56'd0, ret, d};
      e_cnt   = e_cnt + 10'd1;
      if (l) begin
        e_valid = 1'b1; m_load = 1'b0;
      end else if (e_cnt == 10'd512) begin
        e_err = 1'b1; m_load = 1'b0;
      end
    end
    e_rdy = m_load;
  endtask

  task automatic cycle(input logic s, input logic v, input logic l, input logic [14:0] d);
    start = s;
    cfg_if.cfg_in_vld  = v;
    cfg_if.cfg_in_last = l;
    cfg_if.cfg_in_data = d;
    @(posedge clk);
    model_step(s, v, l, d);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; cfg_if.cfg_in_vld = 1'b0; cfg_if.cfg_in_last = 1'b0; cfg_if.cfg_in_data = 15'd0;
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_wr_en", {71'd0, conf_bram_wr_en}, 72'd0);
    chk("rst_rdy", {71'd0, cfg_if.cfg_in_rdy}, 72'd0);
    chk("rst_valid", {71'd0, conf_valid}, 72'd0);
    chk("rst_cnt", {62'd0, entry_cnt}, 72'd0);
    chk("rst_addr", {63'd0, conf_bram_wr_addr}, 72'd0);
    chk("rst_data", conf_bram_wr_data, 72'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cfg_in_rdy", {71'd0, cfg_if.cfg_in_rdy}, {71'd0, e_rdy});
      chk("wr_en", {71'd0, conf_bram_wr_en}, {71'd0, e_wr_en});
      chk("wr_addr", {63'd0, conf_bram_wr_addr}, {63'd0, e_addr});
      chk("wr_data", conf_bram_wr_data, e_data);
      chk("conf_valid", {71'd0, conf_valid}, {71'd0, e_valid});
      chk("load_err", {71'd0, load_err}, {71'd0, e_err});
      chk("entry_cnt", {62'd0, entry_cnt}, {62'd0, e_cnt});
    end
  end

  // Captures BRAM contents for end-of-load inspection
  always @(negedge clk) begin
    if (conf_bram_wr_en === 1'b1) mem[conf_bram_wr_addr] = conf_bram_wr_data;
  end

  initial begin
    rst = 1'b1;
    start = 1'b0; cfg_if.cfg_in_vld = 1'b0; cfg_if.cfg_in_last = 1'b0; cfg_if.cfg_in_data = 15'd0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    do_reset();

    // vld in IDLE is not accepted
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 15'h7ABC);
    chk("idle_no_write", {71'd0, conf_bram_wr_en}, 72'd0);
    chk("idle_cnt", {62'd0, entry_cnt}, 72'd0);

    // Four back-to-back entries
    cycle(1'b1, 1'b0, 1'b0, 15'd0);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, i == 4, 15'(i));
    chk("b2b_addr3", {63'd0, conf_bram_wr_addr}, 72'd3);
    chk("b2b_data3", conf_bram_wr_data, 72'h8004);
    chk("b2b_valid", {71'd0, conf_valid}, 72'd1);
    chk("b2b_cnt", {62'd0, entry_cnt}, 72'd4);
    chk("b2b_mem0", mem[0], 72'h0001);
    cycle(1'b0, 1'b0, 1'b0, 15'd0);

    // Same stream with vld toggling
    cycle(1'b1, 1'b0, 1'b0, 15'd0);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b1, i == 4, 15'(i));
      if (i != 4) cycle(1'b0, 1'b0, 1'b0, 15'h1FFF);
    end
    chk("tog_data3", conf_bram_wr_data, 72'h8004);
    chk("tog_cnt", {62'd0, entry_cnt}, 72'd4);
    cycle(1'b0, 1'b0, 1'b0, 15'd0);

    // Reset in the middle of a load, then reload from address 0
    cycle(1'b1, 1'b0, 1'b0, 15'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 15'(i + 16));
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 15'd0);
    cycle(1'b0, 1'b1, 1'b1, 15'h0055);
    chk("reload_addr", {63'd0, conf_bram_wr_addr}, 72'd0);
    chk("reload_data", conf_bram_wr_data, 72'h8055);

    // start during LOAD is ignored
    cycle(1'b1, 1'b0, 1'b0, 15'd0);
    cycle(1'b0, 1'b1, 1'b0, 15'h0A);
    cycle(1'b1, 1'b1, 1'b0, 15'h0B);
    cycle(1'b1, 1'b0, 1'b0, 15'h0);
    cycle(1'b0, 1'b1, 1'b1, 15'h0C);
    chk("ign_start_cnt", {62'd0, entry_cnt}, 72'd3);
    chk("ign_start_addr", {63'd0, conf_bram_wr_addr}, 72'd2);

    // Full table with last on the final address
    cycle(1'b1, 1'b0, 1'b0, 15'd0);
    for (int i = 0; i < 512; i++) cycle(1'b0, 1'b1, i == 511, 15'($urandom));
    chk("full_addr", {63'd0, conf_bram_wr_addr}, 72'd511);
    chk("full_ret", {71'd0, conf_bram_wr_data[15]}, 72'd1);
    chk("full_valid", {71'd0, conf_valid}, 72'd1);
    chk("full_err", {71'd0, load_err}, 72'd0);
    chk("full_cnt", {62'd0, entry_cnt}, 72'd512);

    // Overflow: 513 entries, no last
    cycle(1'b1, 1'b0, 1'b0, 15'd0);
    for (int i = 0; i < 513; i++) cycle(1'b0, 1'b1, 1'b0, 15'(i));
    chk("ovf_err", {71'd0, load_err}, 72'd1);
    chk("ovf_valid", {71'd0, conf_valid}, 72'd0);
    chk("ovf_rdy", {71'd0, cfg_if.cfg_in_rdy}, 72'd0);
    chk("ovf_cnt", {62'd0, entry_cnt}, 72'd512);
    chk("ovf_no_513", {71'd0, conf_bram_wr_en}, 72'd0);
    chk("ovf_mem511", mem[511], 72'h81FF);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom % 24) == 0, $urandom % 2, ($urandom % 12) == 0, 15'($urandom));
      if (($urandom % 1500) == 0) do_reset();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conf_encoder.md
# conf_encoder

Configuration loader for the SWIN_BRAM configuration BRAM: the write-side counterpart of the configuration decoder. Accepts a stream of configuration entries over a valid/ready handshake, packs each entry into one RAMB36-wide word with a return (wrap) flag on the final entry, and writes the words to consecutive BRAM addresses from 0. Signals completion so the decoder can be enabled, and flags tables that overflow the BRAM depth.

## Interface
- CONF_DATA_WIDTH, 15, width of one configuration entry; occupies word bits [CONF_DATA_WIDTH-1:0].
- CONF_ADDR_WIDTH, 9, BRAM address width; table depth = 2^CONF_ADDR_WIDTH.
- RAMB36_WIDTH, 72, BRAM data width; must be >= CONF_DATA_WIDTH+1.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a new table load; honored only in IDLE, DONE, ERR.
- cfg_in_vld  in  1  entry valid.
- cfg_in_data  in  CONF_DATA_WIDTH  configuration entry.
- cfg_in_last  in  1  marks final entry of the table; qualified by cfg_in_vld.
- cfg_in_rdy  out  1  entry accepted when cfg_in_vld & cfg_in_rdy.
- conf_bram_wr_en  out  1  BRAM write strobe.
- conf_bram_wr_addr  out  CONF_ADDR_WIDTH  BRAM write address.
- conf_bram_wr_data  out  RAMB36_WIDTH  BRAM write word.
- conf_valid  out  1  level; complete table in BRAM, decoder may be enabled.
- load_err  out  1  level; overflow during last load.
- entry_cnt  out  CONF_ADDR_WIDTH+1  entries written in current/last load.

## Operation
- Word format: [CONF_DATA_WIDTH-1:0] = cfg_in_data; bit CONF_DATA_WIDTH = ret flag (1 only on final entry); remaining upper bits 0.
- States: IDLE, LOAD, DONE, ERR.
- IDLE/DONE/ERR -> LOAD on start: clear write pointer to 0, entry_cnt to 0, conf_valid and load_err to 0.
- LOAD: cfg_in_rdy = 1. Each accepted beat writes one word at the write pointer, then pointer +1, entry_cnt +1.
- LOAD -> DONE on accepted beat with cfg_in_last=1: word written with ret=1; conf_valid set.
- LOAD -> ERR on accepted beat at pointer = 2^CONF_ADDR_WIDTH-1 with cfg_in_last=0: word written with ret forced to 1 (decoder still wraps safely); load_err set; conf_valid stays 0.
- Last entry at final address with cfg_in_last=1: normal DONE, no error.
- start while in LOAD: ignored. cfg_in_vld outside LOAD: not accepted (rdy=0), no write.
- Reset at any time: state IDLE, all outputs 0; a partially loaded table is left invalid (conf_valid=0).

## Timing
- Reset values: cfg_in_rdy=0, conf_bram_wr_en=0, conf_bram_wr_addr=0, conf_bram_wr_data=0, conf_valid=0, load_err=0, entry_cnt=0.
- start sampled at cycle t -> LOAD and cfg_in_rdy=1 from t+1.
- Beat accepted at cycle n -> conf_bram_wr_en=1 with addr/data registered at n+1; full throughput, one write per cycle.
- cfg_in_rdy drops in the cycle after the terminating beat (last or overflow); no further beats accepted.
- conf_valid / load_err rise in the same cycle as the terminating write (n+1); entry_cnt updated with each write.
- conf_bram_wr_en is 0 in every cycle without a preceding accepted beat.

## Structure
- Shared package conf_pkg: CONF_DATA_WIDTH, CONF_ADDR_WIDTH, RAMB36_WIDTH defaults, RET_BIT index (= CONF_DATA_WIDTH), state enum; same package used by the decoder for ret-flag extraction.
- Single module; word packing is a small combinational sub-function, optional sub-module conf_word_pack.

## Test plan
- Reset mid-LOAD after 3 entries -> all outputs 0, state IDLE, conf_valid=0; next start reloads from addr 0.
- start, 4 back-to-back entries 0x0001..0x0004, last on 4th -> writes at addr 0..3 in consecutive cycles, addr 3 data = 0x0_8004 (ret bit 15 set), conf_valid=1, entry_cnt=4.
- Same stream with cfg_in_vld toggled every other cycle -> identical write sequence, writes only the cycle after each accepted beat.
- 512 entries, last on 512th -> final write addr 511 ret=1, conf_valid=1, load_err=0, entry_cnt=512.
- 513 entries, no last within first 512 -> addr 511 written with ret=1, load_err=1, conf_valid=0, cfg_in_rdy=0, 513th not accepted.
- start pulsed during LOAD and cfg_in_vld asserted in IDLE -> both ignored, no writes, pointer unchanged.
